// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin grant of a shared active-low PCI-style bus with turnaround and grant timeout
module rr_bus_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         req_n,
    input  logic                 frame_n,
    input  logic                 irdy_n,
    output logic [N-1:0]         gnt_n,
    output logic [$clog2(N)-1:0] owner,
    output logic                 bus_busy,
    output logic                 timeout
);
    localparam int OW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [OW-1:0] LAST = OW'(N - 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GRANT, BUSY, TURN} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d, ptr_q, ptr_d, win;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic            busy_q, to_q, to_d, found, grant, any_req;

    assign any_req = ~&req_n;

    // first requester at or after the pointer, wrapping mod N
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && !req_n[OW'((int'(ptr_q) + k) % N)]) begin
                win   = OW'((int'(ptr_q) + k) % N);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        grant   = 1'b0;
        case (state_q)
            IDLE:  grant = any_req;
            GRANT: begin
                if (!frame_n)
                    state_d = BUSY;
                else if (req_n[owner_q])
                    state_d = TURN;
                else if (cnt_q == TMAX) begin
                    state_d = TURN;
                    to_d    = 1'b1;
                end else
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            end
            BUSY:  state_d = (frame_n && irdy_n) ? TURN : BUSY;
            TURN:  begin
                state_d = IDLE;
                grant   = any_req;
            end
            default: state_d = IDLE;
        endcase
        if (grant) begin
            state_d = GRANT;
            owner_d = win;
            ptr_d   = (win == LAST) ? '0 : win + 1'b1;
            cnt_d   = '0;
        end
        gnt_d = '1;
        if (state_d == GRANT)
            gnt_d[owner_d] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '1;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            busy_q  <= (state_d == BUSY);
            to_q    <= to_d;
        end
    end

    assign gnt_n    = gnt_q;
    assign owner    = owner_q;
    assign bus_busy = busy_q;
    assign timeout  = to_q;
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb_rr_bus_arbiter: directed vector table plus timeout, boundary and async-reset sequences
module tb_rr_bus_arbiter;
    logic       clk = 1'b0, reset_n = 1'b0, frame_n = 1'b1, irdy_n = 1'b1;
    logic [3:0] req_n = 4'b1111;
    logic [3:0] gnt_n;
    logic [1:0] owner;
    logic       bus_busy, timeout;
    int         n_chk = 0, n_fail = 0;

    rr_bus_arbiter #(.N(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .req_n(req_n), .frame_n(frame_n), .irdy_n(irdy_n),
        .gnt_n(gnt_n), .owner(owner), .bus_busy(bus_busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] r;
        logic       f, i;
        logic [3:0] g;
        logic       b, t;
        logic [1:0] o;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] r, input logic f, input logic i,
                                input logic [3:0] g, input logic b, input logic t, input logic [1:0] o);
        return '{r: r, f: f, i: i, g: g, b: b, t: t, o: o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        n_chk++;
        if (!$onehot0(~gnt_n)) begin
            n_fail++;
            $display("FAIL onehot0: gnt_n got %b expected at most one low bit", gnt_n);
        end
    end

    vec_t tv[$];
    int   lows, pulses;
    logic done;

    initial begin
        tv.push_back(mk(4'b1111, 1, 1, 4'b1111, 0, 0, 2'd0));
        tv.push_back(mk(4'b1111, 1, 1, 4'b1111, 0, 0, 2'd0));
        tv.push_back(mk(4'b1101, 1, 1, 4'b1101, 0, 0, 2'd1));
        tv.push_back(mk(4'b1101, 1, 1, 4'b1101, 0, 0, 2'd1));
        tv.push_back(mk(4'b1101, 0, 0, 4'b1111, 1, 0, 2'd1));
        tv.push_back(mk(4'b1111, 0, 0, 4'b1111, 1, 0, 2'd1));
        tv.push_back(mk(4'b1111, 1, 0, 4'b1111, 1, 0, 2'd1));
        tv.push_back(mk(4'b1111, 1, 1, 4'b1111, 0, 0, 2'd1));
        tv.push_back(mk(4'b1111, 1, 1, 4'b1111, 0, 0, 2'd1));
        tv.push_back(mk(4'b0000, 1, 1, 4'b1011, 0, 0, 2'd2));
        tv.push_back(mk(4'b0000, 0, 1, 4'b1111, 1, 0, 2'd2));
        tv.push_back(mk(4'b0000, 0, 1, 4'b1111, 1, 0, 2'd2));
        tv.push_back(mk(4'b0000, 1, 1, 4'b1111, 0, 0, 2'd2));
        tv.push_back(mk(4'b0000, 1, 1, 4'b0111, 0, 0, 2'd3));
        tv.push_back(mk(4'b0000, 0, 1, 4'b1111, 1, 0, 2'd3));
        tv.push_back(mk(4'b0000, 1, 1, 4'b1111, 0, 0, 2'd3));
        tv.push_back(mk(4'b0000, 1, 1, 4'b1110, 0, 0, 2'd0));
        tv.push_back(mk(4'b0000, 0, 1, 4'b1111, 1, 0, 2'd0));
        tv.push_back(mk(4'b0000, 1, 1, 4'b1111, 0, 0, 2'd0));
        tv.push_back(mk(4'b0000, 1, 1, 4'b1101, 0, 0, 2'd1));
        tv.push_back(mk(4'b0000, 0, 1, 4'b1111, 1, 0, 2'd1));
        tv.push_back(mk(4'b0000, 1, 1, 4'b1111, 0, 0, 2'd1));
        tv.push_back(mk(4'b0000, 1, 1, 4'b1011, 0, 0, 2'd2));
        tv.push_back(mk(4'b0111, 1, 1, 4'b1111, 0, 0, 2'd2));
        tv.push_back(mk(4'b0111, 1, 1, 4'b0111, 0, 0, 2'd3));
        tv.push_back(mk(4'b1111, 0, 1, 4'b1111, 1, 0, 2'd3));
        tv.push_back(mk(4'b1111, 1, 1, 4'b1111, 0, 0, 2'd3));
        tv.push_back(mk(4'b1111, 0, 0, 4'b1111, 0, 0, 2'd3));
        tv.push_back(mk(4'b1111, 0, 0, 4'b1111, 0, 0, 2'd3));
        tv.push_back(mk(4'b1111, 1, 1, 4'b1111, 0, 0, 2'd3));

        req_n = 4'b0000;
        tick();
        tick();
        chk("rst_gnt", 32'(gnt_n), 32'hf);
        chk("rst_busy", 32'(bus_busy), 0);
        chk("rst_to", 32'(timeout), 0);
        chk("rst_owner", 32'(owner), 0);
        req_n   = 4'b1111;
        reset_n = 1'b1;

        foreach (tv[k]) begin
            req_n   = tv[k].r;
            frame_n = tv[k].f;
            irdy_n  = tv[k].i;
            tick();
            chk($sformatf("vec%0d_gnt", k), 32'(gnt_n), 32'(tv[k].g));
            chk($sformatf("vec%0d_busy", k), 32'(bus_busy), 32'(tv[k].b));
            chk($sformatf("vec%0d_to", k), 32'(timeout), 32'(tv[k].t));
            chk($sformatf("vec%0d_owner", k), 32'(owner), 32'(tv[k].o));
        end

        // silent master 2 must hold the grant exactly TIMEOUT cycles
        req_n = 4'b1011;
        tick();
        chk("to_first_gnt", 32'(gnt_n), 32'hb);
        lows   = 1;
        pulses = 0;
        done   = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            if (gnt_n == 4'b1011) begin
                lows++;
                pulses += int'(timeout);
            end else
                done = 1'b1;
        end
        chk("to_low_cycles", 32'(lows), 16);
        chk("to_early_pulse", 32'(pulses), 0);
        chk("to_pulse", 32'(timeout), 1);
        chk("to_turn_gnt", 32'(gnt_n), 32'hf);
        tick();
        chk("to_regrant", 32'(gnt_n), 32'hb);
        chk("to_pulse_once", 32'(timeout), 0);
        req_n = 4'b1111;
        tick();
        tick();
        chk("to_idle", 32'(gnt_n), 32'hf);

        // frame arriving on the last wait cycle wins over the timeout
        req_n = 4'b1011;
        tick();
        repeat (15) tick();
        chk("bd_still_gnt", 32'(gnt_n), 32'hb);
        frame_n = 1'b0;
        tick();
        chk("bd_busy", 32'(bus_busy), 1);
        chk("bd_no_pulse", 32'(timeout), 0);
        chk("bd_gnt_off", 32'(gnt_n), 32'hf);
        frame_n = 1'b1;
        req_n   = 4'b1111;
        tick();
        chk("bd_turn_no_pulse", 32'(timeout), 0);
        chk("bd_turn_busy", 32'(bus_busy), 0);
        tick();

        // async reset mid-BUSY with the pointer away from 0
        req_n = 4'b1110;
        tick();
        chk("ar_gnt0", 32'(gnt_n), 32'he);
        frame_n = 1'b0;
        tick();
        chk("ar_busy", 32'(bus_busy), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_gnt_rel", 32'(gnt_n), 32'hf);
        chk("ar_busy_rel", 32'(bus_busy), 0);
        req_n   = 4'b0000;
        frame_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("ar_first_gnt", 32'(gnt_n), 32'he);
        chk("ar_first_owner", 32'(owner), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
